// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcode/funct codes,
// the packed control bundle layout, field encodings and the ALU-control helper.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 18;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // MemtoReg encodings
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  // PCSrc encodings
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  // RegDst encodings
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Control bundle, MSB first; bit offsets follow from field order:
  // reg_write[17] mem_to_reg[16:15] mem_write[14] alu_control[13:10]
  // alu_src1[9] alu_src2[8] reg_dst[7:6] branch[5] ext_op[4] lu_op[3]
  // pc_src[2:1] mul_div[0]
  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       mem_write;
    logic [3:0] alu_control;
    logic       alu_src1;
    logic       alu_src2;
    logic [1:0] reg_dst;
    logic       branch;
    logic       ext_op;
    logic       lu_op;
    logic [1:0] pc_src;
    logic       mul_div;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // ALU control: opcode LSB on top, operation class below
  function automatic logic [3:0] alu_control(input logic [5:0] op);
    logic [2:0] low;
    case (op)
      OP_RTYPE:           low = 3'b010;
      OP_BEQ:             low = 3'b001;
      OP_ANDI:            low = 3'b100;
      OP_SLTI, OP_SLTIU:  low = 3'b101;
      default:            low = 3'b000;
    endcase
    return {op[0], low};
  endfunction

endpackage

// File: rtl/pipe_control_unit_decode.sv
// Combinational ID-stage decode: control bundle, destination register,
// whether rt is a source operand, HI/LO usage and illegal-encoding flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic [5:0]            OpCode,
  input  logic [5:0]            Funct,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output ctrl_t                 ctrl,
  output logic [REG_ADDR_W-1:0] dst,
  output logic                  reads_rt,
  output logic                  uses_hilo,
  output logic                  illegal_id
);

  ctrl_t c;
  logic  legal;
  logic  hilo;

  // Classify the instruction and fill in the fields each class needs
  always_comb begin
    c        = CTRL_NOP;
    legal    = 1'b1;
    hilo     = 1'b0;
    reads_rt = 1'b0;
    case (OpCode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = DST_RD;
        reads_rt    = 1'b1;
        case (Funct)
          FN_SLL, FN_SRL, FN_SRA: c.alu_src1 = 1'b1;
          FN_JR: begin
            c.reg_write = 1'b0;
            c.pc_src    = PC_REG;
          end
          FN_JALR: begin
            c.mem_to_reg = M2R_PC;
            c.pc_src     = PC_REG;
          end
          FN_MFHI, FN_MFLO: begin
            hilo  = ENABLE_MULDIV;
            legal = ENABLE_MULDIV;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            c.reg_write = 1'b0;
            c.mul_div   = 1'b1;
            hilo        = ENABLE_MULDIV;
            legal       = ENABLE_MULDIV;
          end
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ;
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MEM;
        c.alu_src2   = 1'b1;
        c.ext_op     = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src2  = 1'b1;
        c.ext_op    = 1'b1;
        reads_rt    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.branch = 1'b1;
        c.ext_op = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        c.branch = 1'b1;
        c.ext_op = 1'b1;
      end
      OP_J: c.pc_src = PC_JUMP;
      OP_JAL: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_PC;
        c.reg_dst    = DST_RA;
        c.pc_src     = PC_JUMP;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src2  = 1'b1;
        c.ext_op    = (OpCode != OP_ANDI);
        c.lu_op     = (OpCode == OP_LUI);
      end
      default: legal = 1'b0;
    endcase
  end

  // Select destination, drop writes to $0, and zero everything when illegal
  always_comb begin
    ctrl       = CTRL_NOP;
    dst        = '0;
    uses_hilo  = 1'b0;
    illegal_id = ~legal;
    if (legal) begin
      ctrl             = c;
      ctrl.alu_control = alu_control(OpCode);
      uses_hilo        = hilo;
      case (c.reg_dst)
        DST_RD:  dst = rd;
        DST_RA:  dst = REG_ADDR_W'(31);
        default: dst = rt;
      endcase
      if (dst == '0) ctrl.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control unit: decodes in ID, carries the control bundle and
// destination through ID/EX, EX/MEM and MEM/WB, and generates load-use
// stalls, branch/jump flushes and the multi-cycle mult/div interlock.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int MULDIV_LATENCY = 32,
  parameter bit ENABLE_MULDIV  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            OpCode,
  input  logic [5:0]            Funct,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [CTRL_W-1:0]     mem_ctrl,
  output logic [CTRL_W-1:0]     wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  stall,
  output logic                  flush,
  output logic                  illegal
);

  localparam int CNT_W = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MULDIV_LATENCY - 1);

  ctrl_t                 id_ctrl;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_reads_rt;
  logic                  id_uses_hilo;
  logic                  id_illegal;

  ctrl_t                 ex_q, mem_q, wb_q;
  logic [REG_ADDR_W-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
  logic [CNT_W-1:0]      busy_cnt;
  logic                  illegal_q;

  logic                  ex_is_load;
  logic                  load_use;
  logic                  muldiv_busy;
  logic                  jump_in_ex;
  logic                  advance;
  ctrl_t                 ex_next;
  logic [REG_ADDR_W-1:0] ex_dst_next;

  ctrl_decode #(
    .REG_ADDR_W    (REG_ADDR_W),
    .ENABLE_MULDIV (ENABLE_MULDIV)
  ) u_decode (
    .OpCode     (OpCode),
    .Funct      (Funct),
    .rt         (id_rt),
    .rd         (id_rd),
    .ctrl       (id_ctrl),
    .dst        (id_dst),
    .reads_rt   (id_reads_rt),
    .uses_hilo  (id_uses_hilo),
    .illegal_id (id_illegal)
  );

  // Hazard detection; an empty ID slot never requests a stall, and a flush
  // overrides any stall because the ID instruction is being discarded anyway
  always_comb begin
    ex_is_load  = (ex_q.mem_to_reg == M2R_MEM) && ex_q.reg_write && (ex_dst_q != '0);
    load_use    = id_valid && ex_is_load &&
                  ((ex_dst_q == id_rs) || (id_reads_rt && (ex_dst_q == id_rt)));
    muldiv_busy = id_valid && id_uses_hilo && (busy_cnt != '0);
    jump_in_ex  = (ex_q.pc_src != PC_SEQ) && !ex_q.branch;
    flush       = ex_branch_taken || jump_in_ex;
    stall       = !flush && (load_use || muldiv_busy);
    advance     = id_valid && !flush && !stall;
    ex_next     = advance ? id_ctrl : CTRL_NOP;
    ex_dst_next = advance ? id_dst : '0;
  end

  // Pipeline registers: EX takes the decoded instruction or a bubble, later stages just shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q      <= CTRL_NOP;
      mem_q     <= CTRL_NOP;
      wb_q      <= CTRL_NOP;
      ex_dst_q  <= '0;
      mem_dst_q <= '0;
      wb_dst_q  <= '0;
    end else begin
      ex_q      <= ex_next;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      ex_dst_q  <= ex_dst_next;
      mem_dst_q <= ex_dst_q;
      wb_dst_q  <= mem_dst_q;
    end
  end

  // Mult/div busy counter: loads when a mult/div actually enters EX, then counts down to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (ex_next.mul_div) begin
      busy_cnt <= BUSY_LOAD;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

  // Illegal flag travels with the EX bundle, so bubbles and flushes clear it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= advance && id_illegal;
    end
  end

  assign ex_ctrl  = ex_q;
  assign mem_ctrl = mem_q;
  assign wb_ctrl  = wb_q;
  assign ex_dst   = ex_dst_q;
  assign mem_dst  = mem_dst_q;
  assign wb_dst   = wb_dst_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: one instance with a 4-cycle mult/div
// and one with no interlock, driven by the same ID stream.
module tb_pipe_control_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_branch_taken;

  logic [17:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
  logic        stall, flush, illegal;

  logic [17:0] ex_ctrl1, mem_ctrl1, wb_ctrl1;
  logic [4:0]  ex_dst1, mem_dst1, wb_dst1;
  logic        stall1, flush1, illegal1;

  int checkCount = 0;
  int errorCount = 0;

  pipe_control_unit #(.REG_ADDR_W(5), .MULDIV_LATENCY(4), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .OpCode(OpCode), .Funct(Funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .stall(stall), .flush(flush), .illegal(illegal)
  );

  pipe_control_unit #(.REG_ADDR_W(5), .MULDIV_LATENCY(1), .ENABLE_MULDIV(1'b1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .OpCode(OpCode), .Funct(Funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_ctrl(ex_ctrl1), .mem_ctrl(mem_ctrl1), .wb_ctrl(wb_ctrl1),
    .ex_dst(ex_dst1), .mem_dst(mem_dst1), .wb_dst(wb_dst1),
    .stall(stall1), .flush(flush1), .illegal(illegal1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack a control bundle from individual field values, MSB first
  function automatic logic [17:0] mk(input logic rw, input logic [1:0] m2r, input logic mw,
                                     input logic [3:0] alu, input logic s1, input logic s2,
                                     input logic [1:0] rdst, input logic br, input logic ext,
                                     input logic lu, input logic [1:0] pcs, input logic md);
    return {rw, m2r, mw, alu, s1, s2, rdst, br, ext, lu, pcs, md};
  endfunction

  localparam logic [17:0] B_ADDI = mk(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
  localparam logic [17:0] B_LW   = mk(1'b1, 2'b01, 1'b0, 4'b1000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
  localparam logic [17:0] B_LW0  = mk(1'b0, 2'b01, 1'b0, 4'b1000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
  localparam logic [17:0] B_ADD  = mk(1'b1, 2'b00, 1'b0, 4'b0010, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [17:0] B_BEQ  = mk(1'b0, 2'b00, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
  localparam logic [17:0] B_MULT = mk(1'b0, 2'b00, 1'b0, 4'b0010, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
  localparam logic [17:0] B_JAL  = mk(1'b1, 2'b10, 1'b0, 4'b1000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the ID-stage inputs and let the combinational outputs settle
  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic taken);
    id_valid        = v;
    OpCode          = op;
    Funct           = fn;
    id_rs           = rs;
    id_rt           = rt;
    id_rd           = rd;
    ex_branch_taken = taken;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyIdle();
    reset = 1'b1;
    #1;
    checkOutput("rst_ex_ctrl",  32'(ex_ctrl),  32'd0);
    checkOutput("rst_wb_ctrl",  32'(wb_ctrl),  32'd0);
    checkOutput("rst_ex_dst",   32'(ex_dst),   32'd0);
    checkOutput("rst_stall",    32'(stall),    32'd0);
    checkOutput("rst_flush",    32'(flush),    32'd0);
    checkOutput("rst_illegal",  32'(illegal),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] addi $8,$0,5 through the pipe");
    applyStimulus(1'b1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 1'b0);
    step();
    checkOutput("addi_ex_ctrl", 32'(ex_ctrl), 32'(B_ADDI));
    checkOutput("addi_ex_dst",  32'(ex_dst),  32'd8);
    applyIdle();
    step();
    checkOutput("addi_mem_ctrl", 32'(mem_ctrl), 32'(B_ADDI));
    step();
    checkOutput("addi_wb_ctrl", 32'(wb_ctrl), 32'(B_ADDI));
    checkOutput("addi_wb_dst",  32'(wb_dst),  32'd8);
    checkOutput("idle_ex_ctrl", 32'(ex_ctrl), 32'd0);

    $display("[TB] lw $9 then add $10,$9,$9");
    applyStimulus(1'b1, 6'h23, 6'h00, 5'd8, 5'd9, 5'd0, 1'b0);
    step();
    checkOutput("lw_ex_ctrl", 32'(ex_ctrl), 32'(B_LW));
    checkOutput("lw_ex_dst",  32'(ex_dst),  32'd9);
    applyStimulus(1'b1, 6'h00, 6'h20, 5'd9, 5'd9, 5'd10, 1'b0);
    checkOutput("lu_stall", 32'(stall), 32'd1);
    checkOutput("lu_flush", 32'(flush), 32'd0);
    step();
    checkOutput("lu_bubble",   32'(ex_ctrl),  32'd0);
    checkOutput("lu_mem_lw",   32'(mem_ctrl), 32'(B_LW));
    checkOutput("lu_stall_off", 32'(stall),   32'd0);
    step();
    checkOutput("add_ex_ctrl", 32'(ex_ctrl), 32'(B_ADD));
    checkOutput("add_ex_dst",  32'(ex_dst),  32'd10);
    applyIdle();
    step();

    $display("[TB] lw $9 then sw / addi using $9 as rt");
    applyStimulus(1'b1, 6'h23, 6'h00, 5'd8, 5'd9, 5'd0, 1'b0);
    step();
    applyStimulus(1'b1, 6'h2b, 6'h00, 5'd8, 5'd9, 5'd0, 1'b0);
    checkOutput("sw_rt_stall", 32'(stall), 32'd1);
    applyStimulus(1'b1, 6'h08, 6'h00, 5'd8, 5'd9, 5'd0, 1'b0);
    checkOutput("addi_rt_no_stall", 32'(stall), 32'd0);
    applyIdle();
    step();

    $display("[TB] lw $0 never stalls");
    applyStimulus(1'b1, 6'h23, 6'h00, 5'd8, 5'd0, 5'd0, 1'b0);
    step();
    checkOutput("lw0_ex_ctrl", 32'(ex_ctrl), 32'(B_LW0));
    applyStimulus(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd10, 1'b0);
    checkOutput("lw0_stall", 32'(stall), 32'd0);
    applyIdle();
    step();

    $display("[TB] branch taken in EX");
    applyStimulus(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    checkOutput("beq_ex_ctrl",  32'(ex_ctrl), 32'(B_BEQ));
    checkOutput("beq_nt_flush", 32'(flush),   32'd0);
    applyStimulus(1'b1, 6'h00, 6'h20, 5'd9, 5'd9, 5'd10, 1'b1);
    checkOutput("beq_t_flush", 32'(flush), 32'd1);
    checkOutput("beq_t_stall", 32'(stall), 32'd0);
    step();
    checkOutput("beq_t_ex_zero", 32'(ex_ctrl), 32'd0);
    applyStimulus(1'b1, 6'h23, 6'h00, 5'd8, 5'd9, 5'd0, 1'b0);
    step();
    applyStimulus(1'b1, 6'h00, 6'h20, 5'd9, 5'd9, 5'd10, 1'b1);
    checkOutput("flush_over_lu_flush", 32'(flush), 32'd1);
    checkOutput("flush_over_lu_stall", 32'(stall), 32'd0);
    step();
    checkOutput("flush_over_lu_ex", 32'(ex_ctrl), 32'd0);
    applyIdle();
    step();

    $display("[TB] mult then mflo");
    applyStimulus(1'b1, 6'h00, 6'h18, 5'd4, 5'd5, 5'd0, 1'b0);
    step();
    checkOutput("mult_ex_ctrl",  32'(ex_ctrl),  32'(B_MULT));
    checkOutput("mult_ex_ctrl1", 32'(ex_ctrl1), 32'(B_MULT));
    applyStimulus(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("md_stall_%0d", i),  32'(stall),  32'd1);
      checkOutput($sformatf("md1_stall_%0d", i), 32'(stall1), 32'd0);
      step();
      checkOutput($sformatf("md_bubble_%0d", i), 32'(ex_ctrl), 32'd0);
      if (i == 0) checkOutput("md1_mflo_ex", 32'(ex_ctrl1), 32'(B_ADD));
    end
    checkOutput("md_stall_done", 32'(stall), 32'd0);
    step();
    checkOutput("mflo_ex_ctrl", 32'(ex_ctrl), 32'(B_ADD));
    checkOutput("mflo_ex_dst",  32'(ex_dst),  32'd12);
    applyIdle();
    step();

    $display("[TB] jal, flushed mult, illegal encodings");
    applyStimulus(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    checkOutput("jal_ex_ctrl", 32'(ex_ctrl), 32'(B_JAL));
    checkOutput("jal_ex_dst",  32'(ex_dst),  32'd31);
    checkOutput("jal_flush",   32'(flush),   32'd1);
    applyStimulus(1'b1, 6'h00, 6'h18, 5'd4, 5'd5, 5'd0, 1'b0);
    checkOutput("jal_stall", 32'(stall), 32'd0);
    step();
    checkOutput("flushed_mult_ex", 32'(ex_ctrl),  32'd0);
    checkOutput("jal_mem_ctrl",    32'(mem_ctrl), 32'(B_JAL));
    applyStimulus(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd12, 1'b0);
    checkOutput("flushed_mult_no_busy", 32'(stall), 32'd0);
    applyStimulus(1'b1, 6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
    step();
    checkOutput("ill_op_ex_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("ill_op_pulse",   32'(illegal), 32'd1);
    applyIdle();
    step();
    checkOutput("ill_op_clear", 32'(illegal), 32'd0);
    applyStimulus(1'b1, 6'h00, 6'h3f, 5'd1, 5'd2, 5'd3, 1'b0);
    step();
    checkOutput("ill_fn_pulse", 32'(illegal), 32'd1);
    applyIdle();
    step();
    checkOutput("ill_fn_clear", 32'(illegal), 32'd0);

    $display("[TB] asynchronous reset during a mult");
    applyStimulus(1'b1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 1'b0);
    step();
    applyStimulus(1'b1, 6'h00, 6'h18, 5'd4, 5'd5, 5'd0, 1'b0);
    step();
    checkOutput("pre_rst_mem", 32'(mem_ctrl), 32'(B_ADDI));
    applyStimulus(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 5'd12, 1'b0);
    checkOutput("pre_rst_stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_ex_ctrl",  32'(ex_ctrl),  32'd0);
    checkOutput("arst_mem_ctrl", 32'(mem_ctrl), 32'd0);
    checkOutput("arst_mem_dst",  32'(mem_dst),  32'd0);
    checkOutput("arst_stall",    32'(stall),    32'd0);
    #1;
    reset = 1'b0;
    step();
    checkOutput("post_rst_mflo", 32'(ex_ctrl), 32'(B_ADD));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
